// File: rtl/i_o_uart_tx.sv
// UART transmitter: byte FIFO feeding a start/data/stop serialiser that
// advances one bit per baud tick. LSB first, no parity, line idles high.
module i_o_uart_tx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LastBit  = BW'(DATA_BITS - 1);
  localparam logic          LastStop = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                 r_state;
  logic [DATA_BITS-1:0]   r_shift;
  logic [BW-1:0]          r_bit_idx;
  logic                   r_stop_idx;
  logic                   r_tx;
  logic                   r_busy;

  logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;

  logic w_push;
  logic w_pop;
  logic w_has_data;
  logic w_frame_end;

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
  assign w_has_data  = (r_count != '0);
  assign in_ready    = (r_count < CW'(FIFO_DEPTH));
  assign w_push      = in_valid && in_ready;
  assign w_frame_end = (r_state == StStop) && (r_stop_idx == LastStop);
  assign w_pop       = tick && w_has_data && ((r_state == StIdle) || w_frame_end);

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign fifo_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else if (tick) begin
      unique case (r_state)
        StIdle: begin
          r_tx <= 1'b1;
          if (w_has_data) begin
            r_shift <= r_mem[r_rd_ptr];
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= StStart;
          end
        end
        StStart: begin
          r_tx      <= r_shift[0];
          r_bit_idx <= '0;
          r_state   <= StData;
        end
        StData: begin
          if (r_bit_idx != LastBit) begin
            r_shift   <= r_shift >> 1;
            r_tx      <= r_shift[1];
            r_bit_idx <= r_bit_idx + BW'(1);
          end else begin
            r_tx       <= 1'b1;
            r_stop_idx <= 1'b0;
            r_state    <= StStop;
          end
        end
        StStop: begin
          r_tx <= 1'b1;
          if (!w_frame_end) begin
            r_stop_idx <= r_stop_idx + 1'b1;
          end else if (w_has_data) begin
            // Next frame starts straight out of the last stop bit.
            r_shift <= r_mem[r_rd_ptr];
            r_tx    <= 1'b0;
            r_state <= StStart;
          end else begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
